pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Generic, parametrised pipeline-stage register. It is the successor to the fixed-field ID/EX latch and is intended to replace the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries an opaque payload with a valid/ready handshake and an optional 2-entry skid buffer, so backpressure does not form a combinational ready chain.
- Supports three control paths:
  - global stall (memory stall);
  - single-cycle flush;
  - sticky "shadow" mode, which discards beats until a resync-marked beat arrives (branch-mispredict squash).

Parameters:
- PAYLOAD_W, 146, payload width in bits (ID/EX default: t, st, sst, n1, n2, wa, we, nn, pc, ppc, npc).
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready).
- CNT_W, 32, width of the accepted-beat counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can take a beat this cycle.
- in_data  in  PAYLOAD_W  upstream payload.
- in_resync  in  1  beat is a resync marker (e.g. t[1:0]==2'b10); clears shadow.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream takes the beat.
- out_data  out  PAYLOAD_W  payload to downstream; all-zero (bubble) when out_valid=0.
- stall  in  1  global freeze (stl_mm).
- flush  in  1  one-cycle kill of all held beats.
- shadow_set  in  1  enter shadow mode (next_invalid).
- shadow  out  1  shadow-mode status.
- beat_cnt  out  CNT_W  count of beats stored (not discarded).

Behaviour:
- Reset (rst=0, asynchronous):
  - v0=v1=0, d0=d1=0, shadow=0, beat_cnt=0;
  - out_valid=0, out_data=0;
  - in_ready=0 while rst=0; in_ready=1 from the first cycle after release.
- Storage: main slot (v0,d0) drives the outputs; skid slot (v1,d1) exists only when SKID=1.
- Handshake terms:
  - acc = in_valid & in_ready;
  - drn = v0 & out_ready & ~stall.
- in_ready:
  - SKID=1: ~v1 & ~stall (state-only).
  - SKID=0: ~stall & (~v0 | out_ready).
- Discard: disc = acc & (shadow | shadow_set | flush). A discarded beat is consumed (upstream sees the handshake) but is never stored or counted.
- Store (acc & ~disc):
  - If the slot is free after drn, the beat goes to the main slot.
  - Otherwise, with SKID=1, it goes to the skid slot.
  - On drn with v1=1, the skid beat moves to the main slot in the same edge. Ordering is strictly FIFO.
- Latency: 1 cycle from acc to out_valid.
- Back-to-back beats with out_ready held high give full throughput, 1 beat/cycle.
- Shadow mode:
  - shadow_set=1 → shadow=1 next edge (overrides the clear condition).
  - shadow=1 & acc & in_resync & ~shadow_set → shadow=0 next edge; that marker beat is itself discarded.
  - Shadow does not clear beats already held.
- flush=1:
  - v0=v1=0, d0=d1=0 at next edge, regardless of stall. It has top priority.
  - A same-cycle drn still counts as delivered downstream.
  - Shadow state is unaffected unless shadow_set is also high.
- stall=1 (without flush): all storage, shadow and beat_cnt hold. in_ready=0 and drn=0.
- beat_cnt increments by 1 per stored beat and wraps modulo 2^CNT_W.
- out_data is forced to 0 whenever v0=0; bubbles carry an all-zero payload, so we=0 downstream.

Decomposition:
- Package pipe_pkg holds:
  - PAYLOAD_W defaults per stage (IFID_W, IDEX_W, EXMEM_W, MEMWB_W);
  - the bubble constant (all-zero);
  - the resync opcode mask/value (2'b10 on t[1:0]);
  - field offset localparams for packing and unpacking the ID/EX payload.
- One natural sub-module is pipe_slot: a valid+data register with load/clear/hold, instantiated once or twice.
- Control logic (handshake, shadow FSM, counter) stays in pipe_stage_skid.

Test Plan:
- Reset: rst low mid-stream with v0=v1=1 → out_valid=0, out_data=0, beat_cnt=0 immediately (async). in_ready=1 on the first cycle after release.
- Throughput:
  - Stimulus: SKID=1; 8 beats, data=1..8, in_valid and out_ready held at 1.
  - Required response: outputs 1..8 on consecutive cycles, 1 cycle latency, beat_cnt=8.
- Backpressure:
  - Stimulus: beats 0xA, 0xB, 0xC; out_ready=0 from cycle 1.
  - Required response: in_ready drops after 0xA and 0xB are stored. After out_ready=1, output order is A, B, C with no loss or duplication.
- Flush/stall:
  - Stimulus: v0=v1=1, then stall=1 and flush=1 together.
  - Required response: both slots cleared next edge, out_valid=0, beat_cnt unchanged. A beat offered during the flush cycle is not delivered.
- Shadow:
  - Stimulus: shadow_set pulse; then beats 0x11, 0x22 (resync=0), 0x33 (resync=1), 0x44.
  - Required response: shadow=1 until after 0x33; only 0x44 is output; beat_cnt +1.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 stored beats.
  - Required response: beat_cnt=1. Beats discarded in shadow do not increment beat_cnt.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: per-stage
// payload widths, the bubble value, the resync marker encoding and the
// ID/EX field layout used to pack and unpack that stage's payload.
package pipe_pkg;

  // Field widths of the ID/EX payload
  localparam int T_W   = 6;
  localparam int ST_W  = 6;
  localparam int SST_W = 6;
  localparam int N_W   = 5;
  localparam int WA_W  = 5;
  localparam int WE_W  = 1;
  localparam int NN_W  = 16;
  localparam int PC_W  = 32;

  // Bit offsets of each ID/EX field, least significant field first
  localparam int T_LSB   = 0;
  localparam int ST_LSB  = T_LSB + T_W;
  localparam int SST_LSB = ST_LSB + ST_W;
  localparam int N1_LSB  = SST_LSB + SST_W;
  localparam int N2_LSB  = N1_LSB + N_W;
  localparam int WA_LSB  = N2_LSB + N_W;
  localparam int WE_LSB  = WA_LSB + WA_W;
  localparam int NN_LSB  = WE_LSB + WE_W;
  localparam int PC_LSB  = NN_LSB + NN_W;
  localparam int PPC_LSB = PC_LSB + PC_W;
  localparam int NPC_LSB = PPC_LSB + PC_W;

  // Default payload widths for each stage boundary
  localparam int IFID_W  = 3 * PC_W;
  localparam int IDEX_W  = NPC_LSB + PC_W;
  localparam int EXMEM_W = T_W + WA_W + WE_W + 3 * PC_W;
  localparam int MEMWB_W = T_W + WA_W + WE_W + 2 * PC_W;

  // A bubble carries an all-zero payload, so its write enable is low
  localparam logic [IDEX_W-1:0] IDEX_BUBBLE = '0;

  // A beat whose t[1:0] matches this pattern resynchronises shadow mode
  localparam logic [1:0] RESYNC_MASK  = 2'b11;
  localparam logic [1:0] RESYNC_VALUE = 2'b10;

  // Shadow mode is a two-state machine
  typedef enum logic {
    SHADOW_OFF = 1'b0,
    SHADOW_ON  = 1'b1
  } shadowState_e;

  // Unpacked view of the ID/EX payload
  typedef struct packed {
    logic [PC_W-1:0]  npc;
    logic [PC_W-1:0]  ppc;
    logic [PC_W-1:0]  pc;
    logic [NN_W-1:0]  nn;
    logic [WE_W-1:0]  we;
    logic [WA_W-1:0]  wa;
    logic [N_W-1:0]   n2;
    logic [N_W-1:0]   n1;
    logic [SST_W-1:0] sst;
    logic [ST_W-1:0]  st;
    logic [T_W-1:0]   t;
  } idexFields_t;

  // True when an opcode field marks a resync beat
  function automatic logic isResync(input logic [T_W-1:0] t);
    logic [1:0] low;
    low = t[1:0];
    return (low & RESYNC_MASK) == RESYNC_VALUE;
  endfunction

  // Packs ID/EX fields into the flat payload using the offsets above
  function automatic logic [IDEX_W-1:0] packIdex(input idexFields_t f);
    logic [IDEX_W-1:0] p;
    p = '0;
    p[T_LSB   +: T_W]   = f.t;
    p[ST_LSB  +: ST_W]  = f.st;
    p[SST_LSB +: SST_W] = f.sst;
    p[N1_LSB  +: N_W]   = f.n1;
    p[N2_LSB  +: N_W]   = f.n2;
    p[WA_LSB  +: WA_W]  = f.wa;
    p[WE_LSB  +: WE_W]  = f.we;
    p[NN_LSB  +: NN_W]  = f.nn;
    p[PC_LSB  +: PC_W]  = f.pc;
    p[PPC_LSB +: PC_W]  = f.ppc;
    p[NPC_LSB +: PC_W]  = f.npc;
    return p;
  endfunction

  // Recovers ID/EX fields from the flat payload
  function automatic idexFields_t unpackIdex(input logic [IDEX_W-1:0] p);
    idexFields_t f;
    f.t   = p[T_LSB   +: T_W];
    f.st  = p[ST_LSB  +: ST_W];
    f.sst = p[SST_LSB +: SST_W];
    f.n1  = p[N1_LSB  +: N_W];
    f.n2  = p[N2_LSB  +: N_W];
    f.wa  = p[WA_LSB  +: WA_W];
    f.we  = p[WE_LSB  +: WE_W];
    f.nn  = p[NN_LSB  +: NN_W];
    f.pc  = p[PC_LSB  +: PC_W];
    f.ppc = p[PPC_LSB +: PC_W];
    f.npc = p[NPC_LSB +: PC_W];
    return f;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a valid bit plus payload.
// Clear wins over load; otherwise the slot holds. A cleared slot also
// zeroes its payload so an empty slot never carries stale data.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = IDEX_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;

  // Next slot contents: clear beats load, load beats hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Slot register, emptied by the asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with an optional two-entry skid
// buffer, a global stall, a one-cycle flush and a sticky shadow mode that
// swallows beats until a resync-marked beat arrives.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = IDEX_W,
  parameter bit SKID      = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_resync,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 shadow_set,
  output logic                 shadow,
  output logic [CNT_W-1:0]     beat_cnt
);

  localparam logic [PAYLOAD_W-1:0] BUBBLE = '0;

  logic                 mainValid, skidValid;
  logic [PAYLOAD_W-1:0] mainData,  skidData;
  logic                 accept, drain, discard, store;
  logic                 mainLoad, mainClear, mainFromSkid;
  logic                 skidLoad, skidClear;
  logic [PAYLOAD_W-1:0] mainIn;

  shadowState_e         shadowState_q, shadowState_d;
  logic [CNT_W-1:0]     beatCnt_q, beatCnt_d;

  // Handshake terms; with the skid buffer, in_ready depends only on state
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = rst & ~skidValid & ~stall;
    end else begin
      in_ready = rst & ~stall & (~mainValid | out_ready);
    end
    accept  = in_valid & in_ready;
    drain   = mainValid & out_ready & ~stall;
    discard = accept & ((shadowState_q == SHADOW_ON) | shadow_set | flush);
    store   = accept & ~discard;
  end

  // Slot steering: flush empties everything, otherwise keep FIFO order
  always_comb begin
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else if (drain && skidValid) begin
      mainLoad     = 1'b1;
      mainFromSkid = 1'b1;
      skidClear    = 1'b1;
    end else if (store && (!mainValid || drain)) begin
      mainLoad = 1'b1;
    end else if (store) begin
      skidLoad = 1'b1;
    end else if (drain) begin
      mainClear = 1'b1;
    end
    mainIn = mainFromSkid ? skidData : in_data;
  end

  pipe_slot #(
    .W(PAYLOAD_W)
  ) u_mainSlot (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (mainLoad),
    .clear_i(mainClear),
    .data_i (mainIn),
    .valid_o(mainValid),
    .data_o (mainData)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(
        .W(PAYLOAD_W)
      ) u_skidSlot (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (skidLoad),
        .clear_i(skidClear),
        .data_i (in_data),
        .valid_o(skidValid),
        .data_o (skidData)
      );
    end else begin : g_noSkid
      assign skidValid = 1'b0;
      assign skidData  = BUBBLE;
    end
  endgenerate

  // Shadow next state: set wins over the resync clear; stall freezes it
  always_comb begin
    shadowState_d = shadowState_q;
    if (!stall || flush) begin
      if (shadow_set) begin
        shadowState_d = SHADOW_ON;
      end else if (shadowState_q == SHADOW_ON && accept && in_resync) begin
        shadowState_d = SHADOW_OFF;
      end
    end
  end

  // Shadow state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadowState_q <= SHADOW_OFF;
    end else begin
      shadowState_q <= shadowState_d;
    end
  end

  // Count only beats that were actually stored, wrapping naturally
  always_comb begin
    beatCnt_d = beatCnt_q;
    if (store) begin
      beatCnt_d = beatCnt_q + CNT_W'(1);
    end
  end

  // Beat counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beatCnt_q <= '0;
    end else begin
      beatCnt_q <= beatCnt_d;
    end
  end

  // Outputs: an empty main slot presents an all-zero bubble
  always_comb begin
    out_valid = mainValid;
    out_data  = mainValid ? mainData : BUBBLE;
    shadow    = (shadowState_q == SHADOW_ON);
    beat_cnt  = beatCnt_q;
  end

endmodule
